spi_slave_byte_if: RTL and testbench

SPI mode-0 slave byte engine inside the Logic_Sniffer, facing the PIC SPI master (cs_n/sclk/mosi/miso). It oversamples the SPI pins on the system clock and delivers each received command/data byte as a one-cycle strobe. It returns one queued response byte per SPI byte, sending an idle filler byte when nothing is queued. It drives dataReady, telling the master to keep clocking while response bytes are pending.

---
 rtl/spi_slave_byte_if.sv | 156 +++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave byte engine: oversampled pins, one-cycle rx byte strobe, single-entry tx holding register.
// Latency: pin edges act SYNC_STAGES+1 clocks later; rx_valid follows the 8th sclk rising event by one clock.
// Backpressure: tx_ready low while the holding byte is pending; a tx_valid seen then is ignored. No rx backpressure.
module spi_slave_byte_if #(
    parameter logic [7:0] IDLE_BYTE   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_ready,
    output logic       busy,
    output logic       abort
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold_dat;
    logic       hold_full;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic reload, shift_in, shift_out, end_frame;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign busy        = (state == ST_ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = tx_shift[7];
    assign data_ready  = hold_full;
    assign tx_ready    = ~hold_full;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cs_n rising wins over any sclk event seen in the same cycle
    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        end_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_ACTIVE;
                    reload    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_nxt = ST_IDLE;
                    end_frame = 1'b1;
                end else if (sclk_rise) begin
                    shift_in = 1'b1;
                    reload   = (bit_cnt == 3'd7);
                end else if (sclk_fall && bit_cnt != 3'd0) begin
                    shift_out = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= IDLE_BYTE;
            hold_dat  <= 8'h00;
            hold_full <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            rx_valid  <= 1'b0;
            abort     <= 1'b0;

            if (reload) begin
                tx_shift <= hold_full ? hold_dat : IDLE_BYTE;
            end
            if (state == ST_IDLE && cs_fall) begin
                bit_cnt <= 3'd0;
            end
            if (shift_in) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end
            if (shift_out) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (end_frame) begin
                abort    <= (bit_cnt != 3'd0);
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end

            // A write only lands when empty, so a same-cycle reload has already taken IDLE_BYTE
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_dat  <= tx_data;
            end else if (reload) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Bench for spi_slave_byte_if: table of single-byte frames, directed multi-byte/abort/reset sequences,
// then random frames checked against a one-entry response queue model.
module tb_spi_slave_byte_if;

    localparam int HALF = 5;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, data_ready, busy, abort;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    int         abort_cnt = 0;
    int         rx_rd = 0;

    spi_slave_byte_if #(.IDLE_BYTE(IDLE), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .data_ready(data_ready), .busy(busy), .abort(abort)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (abort) abort_cnt++;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Master shifts nbits of mo MSB first; samples miso (and data_ready on the last bit) just before each rise
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi, output logic dr);
        mi = 8'h00;
        dr = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            wait_clks(HALF);
            mi = {mi[6:0], spi_miso};
            if (i == nbits - 1) dr = data_ready;
            spi_sclk = 1'b1;
            wait_clks(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        wait_clks(10);
    endtask

    task automatic cs_end();
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic host_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp[$]);
        check_int({name, "_rx_count"}, rx_q.size() - rx_rd, exp.size());
        for (int i = 0; i < exp.size() && rx_rd < rx_q.size(); i++) begin
            check8({name, "_rx_byte"}, rx_q[rx_rd], exp[i]);
            rx_rd++;
        end
        rx_rd = rx_q.size();
    endtask

    task automatic test_1als();
        logic [7:0] got[$];
        logic [7:0] msg[4];
        int         nbytes;
        msg = '{8'h31, 8'h41, 8'h4C, 8'h53};
        nbytes = 0;
        host_write(msg[0]);
        check1("als_dr_pre", data_ready, 1'b1);
        fork
            begin
                for (int k = 1; k < 4; k++) begin
                    for (int t = 0; t < 3000 && !tx_ready; t++) @(negedge clock);
                    check1("als_host_ready", tx_ready, 1'b1);
                    host_write(msg[k]);
                end
            end
            begin
                logic [7:0] mi;
                logic       dr;
                cs_start();
                do begin
                    spi_bits(8'h7F, 8, mi, dr);
                    got.push_back(mi);
                    nbytes++;
                end while (dr && nbytes < 8);
                cs_end();
            end
        join
        check_int("als_nbytes", nbytes, 4);
        for (int k = 0; k < 4 && k < got.size(); k++) check8("als_miso", got[k], msg[k]);
        expect_rx("als", '{8'h7F, 8'h7F, 8'h7F, 8'h7F});
        check1("als_dr_end", data_ready, 1'b0);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic       q_vld;
        logic [7:0] q_dat;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] mi;
        logic       dr;
        logic [7:0] mq[$];
        logic [7:0] exp_rx[$];
        logic [7:0] exp_miso;
        int         ab0;

        vecs[0] = '{8'h02, 1'b0, 8'h00, 8'h02, 8'h00};
        vecs[1] = '{8'h7F, 1'b1, 8'h31, 8'h7F, 8'h31};
        vecs[2] = '{8'hA5, 1'b1, 8'hFF, 8'hA5, 8'hFF};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 8'h5A, 8'hFF, 8'h5A};

        wait_clks(3);
        check8("rst_rx_data", rx_data, 8'h00);
        check1("rst_rx_valid", rx_valid, 1'b0);
        check1("rst_tx_ready", tx_ready, 1'b1);
        check1("rst_data_ready", data_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_abort", abort, 1'b0);
        check1("rst_miso_oe", spi_miso_oe, 1'b0);
        check1("rst_miso", spi_miso, IDLE[7]);
        reset_n = 1'b1;
        wait_clks(5);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].q_vld) host_write(vecs[v].q_dat);
            check1("vec_dr_pre", data_ready, vecs[v].q_vld);
            cs_start();
            check1("vec_busy", busy, 1'b1);
            check1("vec_miso_oe", spi_miso_oe, 1'b1);
            check1("vec_dr_start", data_ready, 1'b0);
            check1("vec_tx_ready", tx_ready, 1'b1);
            spi_bits(vecs[v].mosi, 8, mi, dr);
            check8("vec_miso", mi, vecs[v].exp_miso);
            expect_rx("vec", '{vecs[v].exp_rx});
            cs_end();
            check1("vec_busy_end", busy, 1'b0);
        end

        test_1als();

        cs_start();
        spi_bits(8'hC0, 8, mi, dr);
        spi_bits(8'hFF, 8, mi, dr);
        for (int k = 0; k < 3; k++) spi_bits(8'h00, 8, mi, dr);
        cs_end();
        expect_rx("long", '{8'hC0, 8'hFF, 8'h00, 8'h00, 8'h00});

        ab0 = abort_cnt;
        cs_start();
        spi_bits(8'hA5, 5, mi, dr);
        cs_end();
        check_int("abort_pulses", abort_cnt - ab0, 1);
        expect_rx("abort", '{});
        cs_start();
        spi_bits(8'h00, 8, mi, dr);
        cs_end();
        check_int("abort_after_full", abort_cnt - ab0, 1);
        expect_rx("after_abort", '{8'h00});

        cs_start();
        host_write(8'h77);
        check1("mid_dr", data_ready, 1'b1);
        spi_bits(8'hAA, 4, mi, dr);
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        @(negedge clock);
        check8("mrst_rx_data", rx_data, 8'h00);
        check1("mrst_rx_valid", rx_valid, 1'b0);
        check1("mrst_tx_ready", tx_ready, 1'b1);
        check1("mrst_data_ready", data_ready, 1'b0);
        check1("mrst_busy", busy, 1'b0);
        check1("mrst_abort", abort, 1'b0);
        check1("mrst_miso_oe", spi_miso_oe, 1'b0);
        reset_n = 1'b1;
        wait_clks(10);
        rx_rd = rx_q.size();
        cs_start();
        spi_bits(8'h3C, 8, mi, dr);
        cs_end();
        check8("mrst_next_miso", mi, IDLE);
        expect_rx("mrst_next", '{8'h3C});

        // Random frames against a one-entry response queue; the DUT reloads at frame start and each byte end
        for (int f = 0; f < 20; f++) begin
            int         nb;
            logic       partial;
            logic [7:0] mo;
            exp_rx.delete();
            ab0 = abort_cnt;
            nb = $urandom_range(1, 3);
            partial = ($urandom_range(0, 3) == 0);
            for (int b = -1; b < nb; b++) begin
                if (b == 0) begin
                    cs_start();
                    exp_miso = (mq.size() != 0) ? mq.pop_front() : IDLE;
                end
                if ($urandom_range(0, 1) == 1) begin
                    check1("rnd_tx_ready", tx_ready, mq.size() == 0);
                    mo = 8'($urandom);
                    if (mq.size() == 0) mq.push_back(mo);
                    host_write(mo);
                end
                if (b < 0) continue;
                mo = 8'($urandom);
                spi_bits(mo, 8, mi, dr);
                check8("rnd_miso", mi, exp_miso);
                check1("rnd_dr", dr, mq.size() != 0);
                exp_rx.push_back(mo);
                exp_miso = (mq.size() != 0) ? mq.pop_front() : IDLE;
                wait_clks(6);
            end
            if (partial) spi_bits(8'($urandom), $urandom_range(1, 7), mi, dr);
            cs_end();
            check_int("rnd_abort", abort_cnt - ab0, partial ? 1 : 0);
            expect_rx("rnd", exp_rx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
